// File: rtl/apb_tcc_multi.sv
// Multi-channel timer/capture/compare peripheral on APB: one shared prescaled
// up or up/down counter feeding CH_QTY compare/capture channels with PWM outputs.
module apb_tcc_multi #(
  parameter int APB_AW = 32,
  parameter int APB_DW = 32,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16,
  parameter int CH_QTY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [APB_AW-1:0] paddr_i,
  input  logic [APB_DW-1:0] pwdata_i,
  output logic [APB_DW-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  input  logic              ext_clk_i,
  input  logic [CH_QTY-1:0] cap_i,
  output logic [CH_QTY-1:0] pwm_o,
  output logic              irq_o
);

  localparam int SW = CH_QTY + 1;

  logic              en, updown, oneshot, extclk;
  logic [PRE_W-1:0]  pre, psc;
  logic [CNT_W-1:0]  top, cnt;
  logic              dir;
  logic [SW-1:0]     stat, ien, stat_set;
  logic [CNT_W-1:0]  cmp [CH_QTY];
  logic [CH_QTY-1:0] pwmen, pol, capen;

  logic              ext_p0, ext_p1, ext_p2, ext_rise_p3;
  logic [CH_QTY-1:0] cap_p0, cap_p1, cap_p2, cap_rise_p3;
  logic              tick_p1;

  logic              access, wr, mapped;
  logic [5:0]        idx;
  logic [APB_DW-1:0] rdata;
  logic              wr_ctrl, wr_pre, wr_top, wr_cnt, wr_stat, wr_ien;
  logic [CH_QTY-1:0] wr_cmp, wr_cfg;
  logic              src_tick, cnt_tick, top_hit;
  logic [CH_QTY-1:0] cmp_ev, cap_ev;

  logic unused;
  assign unused = ^{paddr_i[APB_AW-1:8], paddr_i[1:0]};

  assign access    = psel_i & penable_i & ~rst_i;
  assign wr        = access & pwrite_i;
  assign idx       = paddr_i[7:2];
  assign pready_o  = 1'b1;

  assign wr_ctrl = wr & (idx == 6'd0);
  assign wr_pre  = wr & (idx == 6'd1);
  assign wr_top  = wr & (idx == 6'd2);
  assign wr_cnt  = wr & (idx == 6'd3);
  assign wr_stat = wr & (idx == 6'd4);
  assign wr_ien  = wr & (idx == 6'd5);

  always_comb begin
    wr_cmp = '0;
    wr_cfg = '0;
    for (int i = 0; i < CH_QTY; i++) begin
      wr_cmp[i] = wr & (idx == 6'(8 + i));
      wr_cfg[i] = wr & (idx == 6'(16 + i));
    end
  end

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (idx)
      6'd0: rdata[3:0]       = {extclk, oneshot, updown, en};
      6'd1: rdata[PRE_W-1:0] = pre;
      6'd2: rdata[CNT_W-1:0] = top;
      6'd3: rdata[CNT_W-1:0] = cnt;
      6'd4: rdata[SW-1:0]    = stat;
      6'd5: rdata[SW-1:0]    = ien;
      default: begin
        mapped = 1'b0;
        for (int i = 0; i < CH_QTY; i++) begin
          if (idx == 6'(8 + i)) begin
            mapped           = 1'b1;
            rdata[CNT_W-1:0] = cmp[i];
          end
          if (idx == 6'(16 + i)) begin
            mapped     = 1'b1;
            rdata[2:0] = {capen[i], pol[i], pwmen[i]};
          end
        end
      end
    endcase
  end

  assign prdata_o  = access ? rdata : '0;
  assign pslverr_o = access & ~mapped;

  // A CNT load takes priority over a coincident tick and must not raise events.
  assign src_tick = extclk ? ext_rise_p3 : 1'b1;
  assign cnt_tick = en & src_tick & (psc == pre);
  assign top_hit  = cnt_tick & ~wr_cnt &
                    ((top == '0) | ((cnt == top) & ~(updown & dir)));

  always_comb begin
    cmp_ev = '0;
    cap_ev = '0;
    for (int i = 0; i < CH_QTY; i++) begin
      cmp_ev[i] = tick_p1 & ~capen[i] & (cnt == cmp[i]);
      cap_ev[i] = cap_rise_p3[i] & capen[i];
    end
  end

  assign stat_set = {cmp_ev | cap_ev, top_hit};

  // p0/p1 synchronise, p2 holds the previous level, p3 is the registered rising edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ext_p0      <= 1'b0;
      ext_p1      <= 1'b0;
      ext_p2      <= 1'b0;
      ext_rise_p3 <= 1'b0;
      cap_p0      <= '0;
      cap_p1      <= '0;
      cap_p2      <= '0;
      cap_rise_p3 <= '0;
    end else begin
      ext_p0      <= ext_clk_i;
      ext_p1      <= ext_p0;
      ext_p2      <= ext_p1;
      ext_rise_p3 <= ext_p1 & ~ext_p2;
      cap_p0      <= cap_i;
      cap_p1      <= cap_p0;
      cap_p2      <= cap_p1;
      cap_rise_p3 <= cap_p1 & ~cap_p2;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en      <= 1'b0;
      updown  <= 1'b0;
      oneshot <= 1'b0;
      extclk  <= 1'b0;
      pre     <= '0;
      top     <= '0;
      ien     <= '0;
      stat    <= '0;
      irq_o   <= 1'b0;
    end else begin
      if (wr_ctrl) {extclk, oneshot, updown, en} <= pwdata_i[3:0];
      if (top_hit & oneshot) en <= 1'b0;
      if (wr_pre) pre <= pwdata_i[PRE_W-1:0];
      if (wr_top) top <= pwdata_i[CNT_W-1:0];
      if (wr_ien) ien <= pwdata_i[SW-1:0];
      stat  <= (stat & ~(wr_stat ? pwdata_i[SW-1:0] : '0)) | stat_set;
      irq_o <= |(stat & ien);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      psc     <= '0;
      dir     <= 1'b0;
      tick_p1 <= 1'b0;
    end else begin
      if (wr_cnt) begin
        cnt <= pwdata_i[CNT_W-1:0];
        psc <= '0;
      end else begin
        if (!en) psc <= '0;
        else if (src_tick) psc <= (psc == pre) ? '0 : psc + PRE_W'(1);
        if (cnt_tick) begin
          if (top_hit) begin
            if ((top == '0) | ~updown) begin
              cnt <= '0;
              dir <= 1'b0;
            end else begin
              cnt <= top - CNT_W'(1);
              dir <= 1'b1;
            end
          end else if (updown & dir) begin
            if (cnt == '0) begin
              cnt <= CNT_W'(1);
              dir <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
              if (cnt == CNT_W'(1)) dir <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
      tick_p1 <= cnt_tick & ~wr_cnt;
      if (!updown) dir <= 1'b0;
    end
  end

  // Capture beats a same-cycle software write to CMP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CH_QTY; i++) cmp[i] <= '0;
      pwmen <= '0;
      pol   <= '0;
      capen <= '0;
      pwm_o <= '0;
    end else begin
      for (int i = 0; i < CH_QTY; i++) begin
        if (cap_ev[i]) cmp[i] <= cnt;
        else if (wr_cmp[i]) cmp[i] <= pwdata_i[CNT_W-1:0];
        if (wr_cfg[i]) {capen[i], pol[i], pwmen[i]} <= pwdata_i[2:0];
        pwm_o[i] <= ((cnt < cmp[i]) ^ pol[i]) & pwmen[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_tcc_multi.sv
// Directed bench for apb_tcc_multi: register table plus timed PWM, one-shot,
// capture-collision, external-clock and W1C-collision sequences.
module tb_apb_tcc_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, prdata;
  logic        pready, pslverr;
  logic        ext_clk = 1'b0;
  logic [3:0]  cap = '0, pwm;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        er;

  typedef struct {
    logic [31:0] addr;
    logic        do_wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  apb_tcc_multi #(
    .APB_AW(32), .APB_DW(32), .CNT_W(32), .PRE_W(16), .CH_QTY(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .pslverr_o(pslverr), .ext_clk_i(ext_clk),
    .cap_i(cap), .pwm_o(pwm), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    d = prdata;
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int highs, rises, lat;
    logic prev, found;

    vecs[0]  = '{32'h00, 1'b1, 32'hFFFF_FFF0, 32'h0,         1'b0};
    vecs[1]  = '{32'h04, 1'b1, 32'h1234_5678, 32'h0000_5678, 1'b0};
    vecs[2]  = '{32'h08, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{32'h0C, 1'b1, 32'h0000_0123, 32'h0000_0123, 1'b0};
    vecs[4]  = '{32'h20, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{32'h2C, 1'b1, 32'h0000_A5A5, 32'h0000_A5A5, 1'b0};
    vecs[6]  = '{32'h44, 1'b1, 32'hFFFF_FFF8, 32'h0,         1'b0};
    vecs[7]  = '{32'h44, 1'b1, 32'h0000_0003, 32'h3,         1'b0};
    vecs[8]  = '{32'h14, 1'b1, 32'hFFFF_FFFF, 32'h1F,        1'b0};
    vecs[9]  = '{32'h10, 1'b0, 32'h0,         32'h0,         1'b0};
    vecs[10] = '{32'h18, 1'b1, 32'h0000_0001, 32'h0,         1'b1};
    vecs[11] = '{32'h30, 1'b1, 32'h0000_0077, 32'h0,         1'b1};
    vecs[12] = '{32'h50, 1'b1, 32'h0000_0007, 32'h0,         1'b1};
    vecs[13] = '{32'h84, 1'b0, 32'h0,         32'h0,         1'b1};

    // power-on reset
    #2;
    check("por_pwm", pwm, 4'h0);
    check("por_irq", irq, 1'b0);
    check("por_prdata", prdata, 32'h0);
    check("por_pslverr", pslverr, 1'b0);
    check("pready", pready, 1'b1);
    do_reset();

    // register map table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) apb_write(vecs[i].addr, vecs[i].wdata);
      apb_read(vecs[i].addr, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
    end

    // asynchronous reset mid-count
    do_reset();
    apb_write(32'h40, 32'h3);
    apb_write(32'h14, 32'h1);
    apb_write(32'h00, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("run_irq", irq, 1'b1);
    check("run_pwm", pwm, 4'h1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_pwm", pwm, 4'h0);
    check("async_rst_irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apb_read(32'h00, rd, er); check("rst_ctrl", rd, 32'h0);
    apb_read(32'h0C, rd, er); check("rst_cnt", rd, 32'h0);
    apb_read(32'h10, rd, er); check("rst_stat", rd, 32'h0);
    apb_read(32'h40, rd, er); check("rst_chcfg0", rd, 32'h0);
    apb_read(32'h84, rd, er);
    check("rst_0x84_rdata", rd, 32'h0);
    check("rst_0x84_err", er, 1'b1);

    // up-mode PWM
    do_reset();
    apb_write(32'h04, 32'd1);
    apb_write(32'h08, 32'd9);
    apb_write(32'h20, 32'd3);
    apb_write(32'h24, 32'd50);
    apb_write(32'h40, 32'h1);
    apb_write(32'h00, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    prev = pwm[0]; highs = 0; rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (pwm[0]) highs++;
      if (pwm[0] && !prev) rises++;
      prev = pwm[0];
    end
    check("up_pwm_high_cycles", highs, 32'd12);
    check("up_pwm_periods", rises, 32'd2);
    apb_write(32'h00, 32'h0);
    apb_read(32'h10, rd, er); check("up_stat", rd, 32'h1B);

    // up/down PWM with inverted polarity
    do_reset();
    apb_write(32'h08, 32'd4);
    apb_write(32'h20, 32'd2);
    apb_write(32'h40, 32'h3);
    apb_write(32'h00, 32'h3);
    repeat (16) @(posedge clk);
    #1;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (pwm[0]) highs++;
    end
    check("updown_pwm_high_cycles", highs, 32'd25);
    apb_write(32'h00, 32'h6);
    apb_write(32'h0C, 32'h0);
    apb_write(32'h00, 32'h7);
    repeat (30) @(posedge clk);
    apb_read(32'h00, rd, er); check("updown_oneshot_ctrl", rd, 32'h6);
    apb_read(32'h0C, rd, er); check("updown_oneshot_cnt", rd, 32'd3);

    // one-shot interrupt
    do_reset();
    apb_write(32'h08, 32'd5);
    apb_write(32'h14, 32'h1);
    apb_write(32'h00, 32'h5);
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 50 && !found; i++) begin
      @(posedge clk); #1;
      if (irq) begin found = 1'b1; lat = i; end
    end
    check("oneshot_irq_latency", lat, 32'd7);
    apb_read(32'h00, rd, er); check("oneshot_ctrl", rd, 32'h4);
    apb_read(32'h0C, rd, er); check("oneshot_cnt", rd, 32'h0);
    apb_read(32'h10, rd, er); check("oneshot_stat", rd, 32'h1F);
    apb_write(32'h10, 32'h1F);
    check("w1c_irq_still_high", irq, 1'b1);
    @(posedge clk); #1;
    check("w1c_irq_dropped", irq, 1'b0);

    // capture with a colliding CMP2 write
    do_reset();
    apb_write(32'h08, 32'd1000);
    apb_write(32'h48, 32'h4);
    apb_write(32'h00, 32'h1);
    repeat (17) @(posedge clk);
    #1 cap[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h28; pwdata = 32'h55;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    cap[2] = 1'b0;
    apb_write(32'h00, 32'h0);
    apb_read(32'h28, rd, er); check("capture_cmp2", rd, 32'd20);
    apb_read(32'h10, rd, er); check("capture_stat", rd, 32'h8);

    // external clock counting
    do_reset();
    apb_write(32'h08, 32'd100);
    apb_write(32'h00, 32'h9);
    repeat (5) @(posedge clk);
    apb_read(32'h0C, rd, er); check("ext_idle_cnt", rd, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 ext_clk = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 ext_clk = 1'b0;
      @(posedge clk);
    end
    repeat (8) @(posedge clk);
    apb_write(32'h00, 32'h8);
    apb_read(32'h0C, rd, er); check("ext_cnt", rd, 32'd10);

    // W1C clear of TOPEV on the same edge it is set
    do_reset();
    apb_write(32'h00, 32'h9);
    @(posedge clk); #1 ext_clk = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    ext_clk = 1'b0;
    apb_write(32'h00, 32'h8);
    apb_read(32'h10, rd, er); check("w1c_collision_stat", rd, 32'h1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
